// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with DEPTH-entry buffer, redirect flush and stale-response drop.
// Optional FETCH_HALT_EN: opcode 7'h7F parks the fetcher in HALT until redirect or reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;
  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d, req_pc_q;
  logic            out_q, out_d, drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, wr_q;
  logic [31:0]     ibuf_q [DEPTH];
  logic [31:0]     pbuf_q [DEPTH];
  logic            grant, rsp, push, pop, halt;
  // A redirect cancels any request this cycle so the memory never accepts a fetch we would discard.
  assign imem_req    = state_q == REQ && !out_q && count_q < CW'(DEPTH) && !redirect;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = count_q != '0;
  assign instr       = ibuf_q[rd_q];
  assign instr_pc    = pbuf_q[rd_q];
  assign grant       = imem_req && imem_gnt;
  assign rsp         = imem_rvalid && out_q;
  assign push        = rsp && !drop_q && !redirect && state_q == WAIT;
  assign pop         = instr_valid && instr_ready && !redirect;
`ifdef FETCH_HALT_EN
  assign halt = push && imem_rdata[31:25] == 7'h7F;
`else
  assign halt = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      state_d    = REQ;
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      out_d      = out_q && !imem_rvalid;
      drop_d     = out_q && !imem_rvalid;
    end else begin
      state_d    = state_q == IDLE ? REQ : grant ? WAIT : push ? (halt ? HALT : REQ) : state_q;
      fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      out_d      = grant || (out_q && !rsp);
      drop_d     = drop_q && !rsp;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      out_q      <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ibuf_q[i] <= '0;
        pbuf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= grant ? fetch_pc_q : req_pc_q;
      out_q      <= out_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_q       <= redirect ? '0 : rd_q + AW'(pop);
      wr_q       <= redirect ? '0 : wr_q + AW'(push);
      if (push) begin
        ibuf_q[wr_q] <= imem_rdata;
        pbuf_q[wr_q] <= req_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a stallable 1-cycle memory model.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'h1357_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        b_req, b_rvalid, b_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_instr_pc;
  logic        stall = 1'b0, halt_word = 1'b0;
  logic        pend_a = 1'b0, pend_b = 1'b0;
  logic [31:0] paddr_a = '0, paddr_b = '0;
  logic [31:0] b_grants [$];
  logic [31:0] exp_pc;
  int          ncheck = 0, npass = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(1'b1),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata), .redirect(1'b0),
    .redirect_pc(32'h0), .instr_valid(b_valid), .instr_ready(1'b1),
    .instr(b_instr), .instr_pc(b_instr_pc));

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      pend_a  <= 1'b1;
      paddr_a <= imem_addr;
    end else if (!stall) pend_a <= 1'b0;
  end
  assign imem_rvalid = pend_a && !stall;
  assign imem_rdata  = halt_word ? 32'hFE00_0000 : paddr_a ^ K;

  always @(posedge clk) begin
    pend_b  <= b_req;
    paddr_b <= b_addr;
    if (b_req) b_grants.push_back(b_addr);
  end
  assign b_rvalid = pend_b;
  assign b_rdata  = paddr_b ^ K;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_expect(input int n);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (instr_valid && instr_ready) begin
        check("stream_pc", instr_pc, exp_pc);
        check("stream_instr", instr, exp_pc ^ K);
        exp_pc += 32'd4;
        got++;
      end
      tick();
    end
    check("stream_count", got, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
  endtask

  initial begin
    imem_gnt = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", instr_valid, 0);
    tick();
    check("wait_valid", instr_valid, 0);
    check("wait_req", imem_req, 0);
    tick();
    check("lat_valid", instr_valid, 1);
    check("next_addr", imem_addr, 32'h4);
    exp_pc = 32'h0;
    run_expect(8);
    instr_ready = 1'b0;
    repeat (10) tick();
    check("bp_req", imem_req, 0);
    check("bp_count", dut.count_q, 2);
    check("bp_valid", instr_valid, 1);
    check("bp_head", instr_pc, exp_pc);
    instr_ready = 1'b1;
    run_expect(6);
    stall = 1'b1;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    check("redir_req", imem_req, 0);
    tick();
    redirect = 1'b0;
    check("redir_flush", instr_valid, 0);
    check("redir_drop", dut.drop_q, 1);
    check("redir_hold", imem_req, 0);
    repeat (2) tick();
    check("drop_hold", imem_req, 0);
    stall = 1'b0;
    tick();
    check("drop_valid", instr_valid, 0);
    check("redir_req2", imem_req, 1);
    check("redir_addr", imem_addr, 32'h100);
    exp_pc = 32'h100;
    run_expect(4);
    stall = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    imem_gnt = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_req", imem_req, 1);
    stall = 1'b0;
    tick();
    check("late_rvalid", instr_valid, 0);
    tick();
    check("late_rvalid2", instr_valid, 0);
    check("hold_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    exp_pc = 32'h0;
    run_expect(3);
`ifdef FETCH_HALT_EN
    halt_word = 1'b1;
    repeat (6) tick();
    check("halt_req", imem_req, 0);
    tick();
    check("halt_req2", imem_req, 0);
    halt_word = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    exp_pc = 32'h40;
    run_expect(2);
`endif
    check("b_ngrants", b_grants.size() >= 3, 1);
    check("b_grant0", b_grants[0], 32'hFFFF_FFF8);
    check("b_grant1", b_grants[1], 32'hFFFF_FFFC);
    check("b_grant2", b_grants[2], 32'h0000_0000);
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule
